// File: rtl/wb_regfile.sv
// Writeback stage: MEM/WB slot, load extraction, register file with zero register, retire counter.
// Optional macro WB_BYPASS_EN forwards the writeback value to read ports while it is being written.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          in_reg_write,
  input  logic [ADDR_W-1:0]             in_rd,
  input  logic [DATA_W-1:0]             in_alu_result,
  input  logic [DATA_W-1:0]             in_mem_data,
  input  logic                          in_mem_to_reg,
  input  logic [1:0]                    in_load_size,
  input  logic                          in_load_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]   in_byte_off,
  input  logic [31:0]                   in_pc,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  output logic                          wb_valid,
  output logic                          wb_we,
  output logic [ADDR_W-1:0]             wb_rd,
  output logic [DATA_W-1:0]             wb_data,
  output logic [31:0]                   wb_pc,
  output logic [31:0]                   retire_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_result;
  logic              w_sign;
  logic              w_capture;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;

  logic              r_valid;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_pc;
  logic [31:0]       r_retire;
  logic [DATA_W-1:0] r_regs [DEPTH];

  assign in_ready  = !stall;
  assign w_capture = in_valid && !stall && !flush;

  // Offset is in bytes; alignment is not checked here.
  assign w_shifted = in_mem_data >> {in_byte_off, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (in_load_size)
      2'd0: begin
        w_mask = DATA_W'(8'hFF);
        w_sign = w_shifted[7];
      end
      2'd1: begin
        w_mask = DATA_W'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      2'd2: begin
        w_mask = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_mask = '1;
        w_sign = 1'b0;
      end
    endcase
  end

  assign w_load   = (w_shifted & w_mask) | ((!in_load_unsigned && w_sign) ? ~w_mask : '0);
  assign w_result = in_mem_to_reg ? w_load : in_alu_result;

  // Payload fields hold when the slot empties; only valid is cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_pc        <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_reg_write <= in_reg_write;
        r_rd        <= in_rd;
        r_data      <= w_result;
        r_pc        <= in_pc;
      end
    end
  end

  assign w_we = r_valid && r_reg_write && (r_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire <= '0;
    end else if (r_valid) begin
      r_retire <= r_retire + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[r_rd] <= r_data;
    end
  end

  always_comb begin
    rd_data = '0;
    w_addr  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_addr = rd_addr[k*ADDR_W +: ADDR_W];
      if (w_addr != '0) begin
        rd_data[k*DATA_W +: DATA_W] = r_regs[w_addr];
`ifdef WB_BYPASS_EN
        if (w_we && (w_addr == r_rd)) begin
          rd_data[k*DATA_W +: DATA_W] = r_data;
        end
`endif
      end
    end
  end

  assign wb_valid     = r_valid;
  assign wb_we        = w_we;
  assign wb_rd        = r_rd;
  assign wb_data      = r_data;
  assign wb_pc        = r_pc;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: load-extraction vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, stall, flush;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_mem_data;
  logic        in_mem_to_reg;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic [1:0]  in_byte_off;
  logic [31:0] in_pc;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc, retire_count;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_byte_off(in_byte_off), .in_pc(in_pc),
    .rd_addr(rd_addr), .rd_data(rd_data), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .retire_count(retire_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the one entry sitting in writeback.
  logic [31:0] m_regs [32];
  bit          m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_pc, m_cnt;

  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    longint unsigned v, span, field;
    int bits;
    v     = {32'b0, mem} / (64'd1 << (8 * int'(off)));
    bits  = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    span  = 64'd1 << bits;
    field = v % span;
    if (!uns && field >= span / 2) field = field + 64'h1_0000_0000 - span;
    return field[31:0];
  endfunction

  function automatic bit model_we();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (model_we() && a == m_rd) return m_data;
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_valid) begin
      if (m_rw && m_rd != 5'd0) m_regs[m_rd] = m_data;
      m_cnt = m_cnt + 32'd1;
    end
    m_valid = in_valid && !stall && !flush;
    if (m_valid) begin
      m_rw   = in_reg_write;
      m_rd   = in_rd;
      m_pc   = in_pc;
      m_data = in_mem_to_reg ? ref_load(in_mem_data, in_load_size, in_load_unsigned, in_byte_off)
                             : in_alu_result;
    end
  endtask

  task automatic check_all();
    check("in_ready", in_ready, !stall);
    check("wb_valid", wb_valid, m_valid);
    check("wb_we", wb_we, model_we());
    if (m_valid) begin
      check("wb_rd", wb_rd, m_rd);
      check("wb_data", wb_data, m_data);
      check("wb_pc", wb_pc, m_pc);
    end
    check("retire_count", retire_count, m_cnt);
    for (int k = 0; k < NUM_RD; k++)
      check($sformatf("rd_data%0d[a=%0d]", k, rd_addr[k*5 +: 5]),
            rd_data[k*32 +: 32], model_read(rd_addr[k*5 +: 5]));
  endtask

  task automatic set_in(input bit v, input bit st, input bit fl, input bit rw,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                        input bit m2r, input logic [1:0] size, input bit uns,
                        input logic [1:0] off, input logic [31:0] pc);
    in_valid = v; stall = st; flush = fl; in_reg_write = rw; in_rd = rd;
    in_alu_result = alu; in_mem_data = mem; in_mem_to_reg = m2r; in_load_size = size;
    in_load_unsigned = uns; in_byte_off = off; in_pc = pc;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 2'd0, 0, 2'd0, 32'd0);
  endtask

  task automatic tick(input bit rand_rd);
    @(posedge clk);
    model_edge();
    #1;
    if (rand_rd) begin
      rd_addr[4:0] = ($urandom % 2) ? m_rd : 5'($urandom);
      rd_addr[9:5] = ($urandom % 2) ? m_rd : 5'($urandom);
    end
    #1;
    check_all();
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = {a, a};
    #1;
    check({name, "_p0"}, rd_data[31:0], exp);
    check({name, "_p1"}, rd_data[63:32], exp);
  endtask

  typedef struct {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic        m2r;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t vecs [11];
  logic [31:0] cnt0;
  logic [31:0] old5;

  initial begin
    vecs[0]  = '{32'h80FF7F01, 32'h0, 2'd0, 1'b0, 2'd3, 1'b1, 32'hFFFFFF80};
    vecs[1]  = '{32'h80FF7F01, 32'h0, 2'd0, 1'b0, 2'd1, 1'b1, 32'h0000007F};
    vecs[2]  = '{32'h80FF7F01, 32'h0, 2'd1, 1'b1, 2'd2, 1'b1, 32'h000080FF};
    vecs[3]  = '{32'h80FF7F01, 32'h0, 2'd1, 1'b0, 2'd2, 1'b1, 32'hFFFF80FF};
    vecs[4]  = '{32'h80FF7F01, 32'h0, 2'd1, 1'b0, 2'd0, 1'b1, 32'h00007F01};
    vecs[5]  = '{32'h80FF7F01, 32'h0, 2'd0, 1'b0, 2'd2, 1'b1, 32'hFFFFFFFF};
    vecs[6]  = '{32'h80FF7F01, 32'h0, 2'd0, 1'b1, 2'd2, 1'b1, 32'h000000FF};
    vecs[7]  = '{32'h80FF7F01, 32'h0, 2'd2, 1'b0, 2'd0, 1'b1, 32'h80FF7F01};
    vecs[8]  = '{32'h80FF7F01, 32'h0, 2'd3, 1'b0, 2'd0, 1'b1, 32'h80FF7F01};
    vecs[9]  = '{32'h80FF7F01, 32'h12345678, 2'd0, 1'b0, 2'd3, 1'b0, 32'h12345678};
    vecs[10] = '{32'h80FF7F01, 32'h0, 2'd2, 1'b0, 2'd1, 1'b1, 32'h0080FF7F};

    model_reset();
    reset = 1'b1;
    rd_addr = '0;
    idle();
    #1;
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_wb_we", wb_we, 1'b0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_wb_pc", wb_pc, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    stall = 1'b1;
    #1;
    check("reset_in_ready_stall", in_ready, 1'b0);
    stall = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    repeat (2) tick(0);
    #3 reset = 1'b0;

    // Word ALU write to r5
    set_in(1, 0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0, 0, 2'd2, 0, 2'd0, 32'h100);
    tick(0);
    idle();
    check("alu_wb_data", wb_data, 32'hDEADBEEF);
    check("alu_wb_we", wb_we, 1'b1);
`ifdef WB_BYPASS_EN
    read_check("reg5_cycN", 5'd5, 32'hDEADBEEF);
`else
    read_check("reg5_cycN", 5'd5, 32'h0);
`endif
    tick(0);
    read_check("reg5_cycN1", 5'd5, 32'hDEADBEEF);
    check("alu_retire", retire_count, 32'd1);

    // Load extraction table
    for (int i = 0; i < 11; i++) begin
      set_in(1, 0, 0, 1, 5'(10 + i), vecs[i].alu, vecs[i].mem, vecs[i].m2r,
             vecs[i].size, vecs[i].uns, vecs[i].off, 32'h200 + 32'(4 * i));
      tick(0);
      check($sformatf("load_vec%0d", i), wb_data, vecs[i].exp);
    end
    idle();
    tick(0);
    read_check("load_vec0_reg", 5'd10, 32'hFFFFFF80);

    // Zero register
    cnt0 = retire_count;
    set_in(1, 0, 0, 1, 5'd0, 32'h1234, 32'h0, 0, 2'd2, 0, 2'd0, 32'h300);
    tick(0);
    idle();
    check("zero_wb_valid", wb_valid, 1'b1);
    check("zero_wb_we", wb_we, 1'b0);
    read_check("zero_cycN", 5'd0, 32'h0);
    tick(0);
    read_check("zero_cycN1", 5'd0, 32'h0);
    check("zero_retire", retire_count, cnt0 + 32'd1);

    // Flush
    cnt0 = retire_count;
    set_in(1, 0, 1, 1, 5'd9, 32'hAAAA5555, 32'h0, 0, 2'd2, 0, 2'd0, 32'h400);
    tick(0);
    idle();
    check("flush_no_capture", wb_valid, 1'b0);
    tick(0);
    read_check("flush_no_write", 5'd9, 32'h0);
    check("flush_retire", retire_count, cnt0);

    // Stall while an entry is held
    set_in(1, 0, 0, 1, 5'd6, 32'h66, 32'h0, 0, 2'd2, 0, 2'd0, 32'h500);
    tick(0);
    cnt0 = retire_count;
    set_in(1, 1, 0, 1, 5'd8, 32'h88, 32'h0, 0, 2'd2, 0, 2'd0, 32'h504);
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    tick(0);
    check("stall_no_capture", wb_valid, 1'b0);
    check("stall_retire_once", retire_count, cnt0 + 32'd1);
    read_check("stall_held_written", 5'd6, 32'h66);
    tick(0);
    idle();
    check("stall_retire_stable", retire_count, cnt0 + 32'd1);
    read_check("stall_blocked_no_write", 5'd8, 32'h0);

    // Back-to-back same rd
    cnt0 = retire_count;
    set_in(1, 0, 0, 1, 5'd7, 32'h1, 32'h0, 0, 2'd2, 0, 2'd0, 32'h600);
    tick(0);
    set_in(1, 0, 0, 1, 5'd7, 32'h2, 32'h0, 0, 2'd2, 0, 2'd0, 32'h604);
    tick(0);
    idle();
    tick(0);
    read_check("b2b_reg7", 5'd7, 32'h2);
    check("b2b_retire", retire_count, cnt0 + 32'd2);

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) != 0,
             ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom),
             $urandom, $urandom, 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
             $urandom);
      tick(1);
    end
    idle();
    tick(1);

    // Asynchronous reset mid-cycle
    set_in(1, 0, 0, 1, 5'd3, 32'h33, 32'h0, 0, 2'd2, 0, 2'd0, 32'h700);
    tick(0);
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    check("areset_wb_valid", wb_valid, 1'b0);
    check("areset_wb_we", wb_we, 1'b0);
    check("areset_retire", retire_count, 32'd0);
    read_check("areset_reg3", 5'd3, 32'h0);
    read_check("areset_reg5", 5'd5, 32'h0);
    tick(0);
    #2 reset = 1'b0;
    tick(0);
    read_check("post_reset_reg3", 5'd3, 32'h0);
    check("post_reset_retire", retire_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
